// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for the unified memory port arbiter
package mem_arb_pkg;

    localparam int LATW = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_LD  = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - requester selection with loader starvation counter
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       idle,
    input  logic       cpu_elig,
    input  logic       ld_elig,
    input  logic       ld_req,
    input  logic       grant,
    output arb_owner_t winner
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] starve_cnt;

    // CPU wins unless the loader has been passed over STARVE_MAX times in a row
    always_comb begin
        winner = OWN_LD;
        if (cpu_elig && !(ld_elig && starve_cnt == CW'(STARVE_MAX))) begin
            winner = OWN_CPU;
        end
    end

    // Count CPU grants taken while the loader was waiting; saturates at STARVE_MAX
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (idle) begin
            if (grant && winner == OWN_LD) begin
                starve_cnt <= '0;
            end else if (grant && ld_req) begin
                if (starve_cnt != CW'(STARVE_MAX)) begin
                    starve_cnt <= starve_cnt + CW'(1);
                end
            end else if (!ld_req) begin
                starve_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between the CPU and the program loader
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ready,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic [DW-1:0] ld_rdata,
    output logic          ld_ready,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    arb_state_t      state;
    arb_owner_t      owner_q;
    arb_owner_t      winner;
    logic            we_q;
    logic [LATW-1:0] lat_cnt;
    logic            idle;
    logic            cpu_elig;
    logic            ld_elig;
    logic            grant;
    logic            sel_we;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;

    // A requester in its own ready cycle is still showing the old request, so mask it
    assign idle     = (state == IDLE);
    assign cpu_elig = cpu_req && !cpu_ready;
    assign ld_elig  = ld_req && !ld_ready;
    assign grant    = idle && (cpu_elig || ld_elig);
    assign busy     = !idle;

    mem_arb_pick #(
        .STARVE_MAX(STARVE_MAX)
    ) u_pick (
        .clk     (CLK),
        .reset   (Reset),
        .idle    (idle),
        .cpu_elig(cpu_elig),
        .ld_elig (ld_elig),
        .ld_req  (ld_req),
        .grant   (grant),
        .winner  (winner)
    );

    // Steer the winning requester's command toward the latch registers
    always_comb begin
        sel_we    = cpu_we;
        sel_addr  = cpu_addr;
        sel_wdata = cpu_wdata;
        if (winner == OWN_LD) begin
            sel_we    = ld_we;
            sel_addr  = ld_addr;
            sel_wdata = ld_wdata;
        end
    end

    // Access sequencer: latch on grant, strobe once, wait out the latency, return data
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state     <= IDLE;
            owner_q   <= OWN_CPU;
            we_q      <= 1'b0;
            lat_cnt   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_ready <= 1'b0;
            ld_ready  <= 1'b0;
            cpu_rdata <= '0;
            ld_rdata  <= '0;
        end else begin
            cpu_ready <= 1'b0;
            ld_ready  <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        owner_q   <= winner;
                        we_q      <= sel_we;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        mem_en    <= 1'b1;
                        mem_we    <= sel_we;
                        lat_cnt   <= '0;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (lat_cnt == LATW'(MEM_LAT - 1)) begin
                        state <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt + LATW'(1);
                    end
                end
                RESP: begin
                    if (owner_q == OWN_CPU) begin
                        cpu_ready <= 1'b1;
                        if (!we_q) cpu_rdata <= mem_rdata;
                    end else begin
                        ld_ready <= 1'b1;
                        if (!we_q) ld_rdata <= mem_rdata;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int LAT = 2;
    localparam int STV = 3;

    logic        clk;
    logic        rst;
    logic        cpu_req, cpu_we, ld_req, ld_we;
    logic [31:0] cpu_addr, cpu_wdata, ld_addr, ld_wdata;
    logic [31:0] cpu_rdata, ld_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        cpu_ready, ld_ready, mem_en, mem_we, busy;

    logic        b_rst;
    logic        b_cpu_req, b_cpu_we, b_ld_req, b_ld_we;
    logic [31:0] b_cpu_addr, b_cpu_wdata, b_ld_addr, b_ld_wdata;
    logic [31:0] b_cpu_rdata, b_ld_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic        b_cpu_ready, b_ld_ready, b_mem_en, b_mem_we, b_busy;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT), .STARVE_MAX(STV)) dut (
        .CLK(clk), .Reset(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_rdata(ld_rdata), .ld_ready(ld_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_MAX(STV)) dut1 (
        .CLK(clk), .Reset(b_rst),
        .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
        .cpu_rdata(b_cpu_rdata), .cpu_ready(b_cpu_ready),
        .ld_req(b_ld_req), .ld_we(b_ld_we), .ld_addr(b_ld_addr), .ld_wdata(b_ld_wdata),
        .ld_rdata(b_ld_rdata), .ld_ready(b_ld_ready),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, want summary");
        $fatal(1);
    end

    // Memory for the main DUT: data valid only exactly LAT cycles after the strobe
    logic [31:0] mem_arr [256];
    logic [3:0]  age;
    always @(posedge clk) begin
        if (mem_en === 1'b1 && mem_we === 1'b1) mem_arr[mem_addr[9:2]] <= mem_wdata;
        if (rst) age <= 4'd0;
        else if (mem_en === 1'b1) age <= 4'd1;
        else if (age != 4'd0 && age != 4'd15) age <= age + 4'd1;
    end
    assign mem_rdata = (age == 4'(LAT)) ? mem_arr[mem_addr[9:2]] : 32'hBAD0_BAD0;

    // Read-only preloaded memory for the MEM_LAT=1 instance
    logic [3:0] b_age;
    always @(posedge clk) begin
        if (b_rst) b_age <= 4'd0;
        else if (b_mem_en === 1'b1) b_age <= 4'd1;
        else if (b_age != 4'd0 && b_age != 4'd15) b_age <= b_age + 4'd1;
    end
    assign b_mem_rdata = (b_age == 4'd1) ? (b_mem_addr ^ 32'hA5A5_0000) : 32'hBAD0_BAD0;

    // Reference model: transactions scheduled by cycle arithmetic
    int          mc = 0;
    int          free_at = 0;
    bit          has_acc = 0;
    int          ag = 0;
    bit          a_ld = 0;
    bit          a_we = 0;
    logic [31:0] a_addr = 0, a_wdata = 0;
    int          m_cnt = 0;
    logic        e_cpu_ready = 0, e_ld_ready = 0, e_mem_en = 0, e_mem_we = 0, e_busy = 0;
    logic [31:0] e_cpu_rdata = 0, e_ld_rdata = 0, e_mem_addr = 0, e_mem_wdata = 0;
    logic [31:0] ref_mem [256];
    bit          grant_log [$];

    task automatic model_edge();
        bit ec, el, pick_ld;
        if (has_acc && mc == ag + 1 && a_we) ref_mem[a_addr[9:2]] = a_wdata;
        if (rst) begin
            has_acc = 0; free_at = mc + 1; m_cnt = 0;
            e_cpu_ready = 0; e_ld_ready = 0; e_mem_en = 0; e_mem_we = 0; e_busy = 0;
            e_cpu_rdata = 0; e_ld_rdata = 0; e_mem_addr = 0; e_mem_wdata = 0;
        end else begin
            ec = cpu_req && !e_cpu_ready;
            el = ld_req && !e_ld_ready;
            e_cpu_ready = 0;
            e_ld_ready = 0;
            if (has_acc && mc + 1 == ag + LAT + 2) begin
                if (a_ld) begin
                    e_ld_ready = 1;
                    if (!a_we) e_ld_rdata = ref_mem[a_addr[9:2]];
                end else begin
                    e_cpu_ready = 1;
                    if (!a_we) e_cpu_rdata = ref_mem[a_addr[9:2]];
                end
                has_acc = 0;
            end
            if (mc >= free_at) begin
                if (ec || el) begin
                    pick_ld = !ec || (el && m_cnt == STV);
                    if (pick_ld) m_cnt = 0;
                    else if (ld_req) m_cnt = (m_cnt < STV) ? m_cnt + 1 : STV;
                    else m_cnt = 0;
                    has_acc = 1; ag = mc; a_ld = pick_ld;
                    a_we    = pick_ld ? ld_we : cpu_we;
                    a_addr  = pick_ld ? ld_addr : cpu_addr;
                    a_wdata = pick_ld ? ld_wdata : cpu_wdata;
                    free_at = mc + LAT + 2;
                    e_mem_addr = a_addr;
                    e_mem_wdata = a_wdata;
                    grant_log.push_back(pick_ld);
                end else if (!ld_req) begin
                    m_cnt = 0;
                end
            end
            e_mem_en = has_acc && (mc == ag);
            e_mem_we = e_mem_en && a_we;
            e_busy = has_acc;
        end
        mc++;
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; b_rst = 1;
        cycle(); cycle();
        total++;
        if ({cpu_ready, ld_ready, mem_en, mem_we, busy, cpu_rdata, ld_rdata, mem_addr, mem_wdata} !== 133'd0) begin
            bad++;
            $display("FAIL reset_outputs: got rdy=%b%b en=%b we=%b busy=%b rd=%h/%h addr=%h wd=%h, want all 0",
                     cpu_ready, ld_ready, mem_en, mem_we, busy, cpu_rdata, ld_rdata, mem_addr, mem_wdata);
        end
        total++;
        if ({b_cpu_ready, b_ld_ready, b_mem_en, b_mem_we, b_busy, b_cpu_rdata, b_ld_rdata, b_mem_addr, b_mem_wdata} !== 133'd0) begin
            bad++;
            $display("FAIL reset_outputs_lat1: got nonzero outputs, want all 0");
        end
        rst = 0; b_rst = 0;
        cycle();
    endtask

    task automatic test_cpu_read();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10; cpu_wdata = 32'h0;
        cycle();
        total++;
        if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h10 || busy !== 1'b1) begin
            bad++;
            $display("FAIL cpu_read_c1: got en=%b we=%b addr=%h busy=%b, want 1 0 00000010 1", mem_en, mem_we, mem_addr, busy);
        end
        cycle();
        total++;
        if (mem_en !== 1'b0 || busy !== 1'b1 || cpu_ready !== 1'b0) begin
            bad++;
            $display("FAIL cpu_read_c2: got en=%b busy=%b rdy=%b, want 0 1 0", mem_en, busy, cpu_ready);
        end
        cycle();
        total++;
        if (cpu_ready !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL cpu_read_c3: got rdy=%b busy=%b, want 0 1", cpu_ready, busy);
        end
        cycle();
        total++;
        if (cpu_ready !== 1'b1 || cpu_rdata !== 32'hA5A5_0010 || busy !== 1'b0) begin
            bad++;
            $display("FAIL cpu_read_c4: got rdy=%b data=%h busy=%b, want 1 a5a50010 0", cpu_ready, cpu_rdata, busy);
        end
        cpu_req = 0;
        cycle();
        total++;
        if (cpu_ready !== 1'b0 || ld_ready !== 1'b0) begin
            bad++;
            $display("FAIL cpu_read_c5: got rdy=%b/%b, want 0/0", cpu_ready, ld_ready);
        end
    endtask

    task automatic test_loader_write();
        int n;
        ld_req = 1; ld_we = 1; ld_addr = 32'h20; ld_wdata = 32'hDEAD_BEEF;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            cycle();
            if (ld_ready === 1'b1) begin n = i; break; end
        end
        ld_req = 0; ld_we = 0;
        total++;
        if (n != 4 || ld_rdata !== 32'h0) begin
            bad++;
            $display("FAIL ld_write: got ready after %0d cycles rdata=%h, want 4 and 00000000", n, ld_rdata);
        end
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h20;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            cycle();
            if (cpu_ready === 1'b1) begin n = i; break; end
        end
        cpu_req = 0;
        total++;
        if (n != 4 || cpu_rdata !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL cpu_read_back: got ready after %0d cycles rdata=%h, want 4 and deadbeef", n, cpu_rdata);
        end
    endtask

    task automatic test_both_held();
        bit seen [$];
        int n0;
        bit got_o, exp_o;
        n0 = grant_log.size();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100;
        ld_req = 1; ld_we = 0; ld_addr = 32'h200;
        for (int i = 0; i < 100 && seen.size() < 8; i++) begin
            cycle();
            if (cpu_ready === 1'b1) seen.push_back(1'b0);
            if (ld_ready === 1'b1) seen.push_back(1'b1);
            if (seen.size() >= 8) begin cpu_req = 0; ld_req = 0; end
        end
        cpu_req = 0; ld_req = 0;
        total++;
        if (seen.size() != 8) begin
            bad++;
            $display("FAIL both_held_count: got %0d ready pulses, want 8", seen.size());
        end
        for (int k = 0; k < 8; k++) begin
            got_o = (k < seen.size()) ? seen[k] : 1'b0;
            exp_o = (n0 + k < grant_log.size()) ? grant_log[n0 + k] : 1'b1;
            total++;
            if (k >= seen.size() || got_o !== exp_o) begin
                bad++;
                $display("FAIL both_held_order[%0d]: got owner %0d, want %0d (0=cpu 1=ld)", k, got_o, exp_o);
            end
        end
        for (int i = 0; i < LAT + 3; i++) cycle();
    endtask

    task automatic test_back_to_back();
        int np, p0, p1;
        logic en5, en6;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h30;
        np = 0; p0 = -1; p1 = -1; en5 = 1'bx; en6 = 1'bx;
        for (int c = 1; c <= 12; c++) begin
            cycle();
            if (c == 5) en5 = mem_en;
            if (c == 6) en6 = mem_en;
            if (cpu_ready === 1'b1) begin
                if (np == 0) p0 = c;
                else if (np == 1) p1 = c;
                np++;
                if (np == 2) cpu_req = 0;
            end
        end
        cpu_req = 0;
        total++;
        if (np != 2 || p0 != 4 || p1 != 9) begin
            bad++;
            $display("FAIL back_to_back_pulses: got %0d pulses at %0d,%0d, want 2 at 4,9", np, p0, p1);
        end
        total++;
        if (en5 !== 1'b0 || en6 !== 1'b1) begin
            bad++;
            $display("FAIL back_to_back_regrant: got mem_en c5=%b c6=%b, want 0 1", en5, en6);
        end
        total++;
        if (cpu_rdata !== 32'hA5A5_0030) begin
            bad++;
            $display("FAIL back_to_back_data: got %h, want a5a50030", cpu_rdata);
        end
    endtask

    task automatic test_reset_mid_access();
        int nwe, nrdy;
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h40; cpu_wdata = 32'h1234_5678;
        cycle();
        cycle();
        rst = 1;
        cycle();
        total++;
        if ({cpu_ready, ld_ready, mem_en, mem_we, busy, cpu_rdata, ld_rdata, mem_addr, mem_wdata} !== 133'd0) begin
            bad++;
            $display("FAIL reset_mid_outputs: got rdy=%b%b en=%b we=%b busy=%b rd=%h/%h addr=%h wd=%h, want all 0",
                     cpu_ready, ld_ready, mem_en, mem_we, busy, cpu_rdata, ld_rdata, mem_addr, mem_wdata);
        end
        rst = 0; cpu_req = 0; cpu_we = 0;
        nwe = 0; nrdy = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (mem_we === 1'b1) nwe++;
            if (cpu_ready === 1'b1) nrdy++;
        end
        total++;
        if (nwe != 0 || nrdy != 0) begin
            bad++;
            $display("FAIL reset_mid_after: got mem_we pulses=%0d cpu_ready pulses=%0d, want 0 0", nwe, nrdy);
        end
    endtask

    task automatic test_random();
        logic [132:0] got, exp;
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 49) == 0);
            cpu_req   = ($urandom_range(0, 3) != 0);
            cpu_we    = $urandom_range(0, 1);
            cpu_addr  = $urandom & 32'hFFFF_FFFC;
            cpu_wdata = $urandom;
            ld_req    = ($urandom_range(0, 2) != 0);
            ld_we     = $urandom_range(0, 1);
            ld_addr   = $urandom & 32'hFFFF_FFFC;
            ld_wdata  = $urandom;
            cycle();
            got = {cpu_ready, ld_ready, mem_en, mem_we, busy, cpu_rdata, ld_rdata, mem_addr, mem_wdata};
            exp = {e_cpu_ready, e_ld_ready, e_mem_en, e_mem_we, e_busy, e_cpu_rdata, e_ld_rdata, e_mem_addr, e_mem_wdata};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL random_cycle[%0d]: got %h, want %h (rdy2,en,we,busy,cpu_rd,ld_rd,addr,wd)", i, got, exp);
            end
        end
        rst = 0; cpu_req = 0; ld_req = 0;
        for (int i = 0; i < LAT + 3; i++) cycle();
    endtask

    task automatic test_lat1();
        int np, p0, p1;
        logic [31:0] d0, d1;
        b_ld_req = 1; b_ld_we = 0; b_ld_addr = 32'h0;
        np = 0; p0 = -1; p1 = -1; d0 = 0; d1 = 0;
        for (int c = 1; c <= 12; c++) begin
            cycle();
            if (b_ld_ready === 1'b1) begin
                if (np == 0) begin p0 = c; d0 = b_ld_rdata; b_ld_addr = 32'h4; end
                else if (np == 1) begin p1 = c; d1 = b_ld_rdata; b_ld_req = 0; end
                np++;
            end
        end
        b_ld_req = 0;
        total++;
        if (np != 2 || p0 != 3 || p1 != 7) begin
            bad++;
            $display("FAIL lat1_pulses: got %0d pulses at %0d,%0d, want 2 at 3,7", np, p0, p1);
        end
        total++;
        if (d0 !== 32'hA5A5_0000 || d1 !== 32'hA5A5_0004) begin
            bad++;
            $display("FAIL lat1_data: got %h,%h, want a5a50000,a5a50004", d0, d1);
        end
        total++;
        if (b_cpu_ready !== 1'b0 || b_cpu_rdata !== 32'h0) begin
            bad++;
            $display("FAIL lat1_cpu_idle: got rdy=%b rdata=%h, want 0 00000000", b_cpu_ready, b_cpu_rdata);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_arr[i] = (32'(i) << 2) ^ 32'hA5A5_0000;
            ref_mem[i] = (32'(i) << 2) ^ 32'hA5A5_0000;
        end
        rst = 1; b_rst = 1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        ld_req = 0; ld_we = 0; ld_addr = 0; ld_wdata = 0;
        b_cpu_req = 0; b_cpu_we = 0; b_cpu_addr = 0; b_cpu_wdata = 0;
        b_ld_req = 0; b_ld_we = 0; b_ld_addr = 0; b_ld_wdata = 0;
        test_reset();
        test_cpu_read();
        test_loader_write();
        test_both_held();
        test_back_to_back();
        test_reset_mid_access();
        test_random();
        test_lat1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
